// File: rtl/lut_engine_rr.sv
// lut_engine_rr
// Multi-channel LUT evaluation engine. N_LUTS writable tables of 2^ADDR_WIDTH
// signed entries, each with its own wrap/clamp edge mode, are shared by N_CH
// requesters under round-robin arbitration. A request returns
//   base + floor((next - base) * frac / 2^FRAC_WIDTH)
// computed by a shift-add loop that consumes one fraction bit per cycle.
//
// Ports
//   clk, reset            clock; synchronous active-low reset
//   req[N_CH]             per-channel request, held until req_ack
//   req_handle            per-channel LUT handle, channel c at [c*HW +: HW]
//   req_arg               per-channel argument, channel c at [c*DW +: DW]
//   req_ack[N_CH]         one-hot, one-cycle grant pulse
//   resp_valid[N_CH]      one-hot, one-cycle response pulse
//   resp_data             signed result, held until the next response
//   resp_err              invalid-handle flag, qualified by resp_valid
//   busy                  engine not idle
//   wr_en/wr_lut/wr_addr/wr_data   LUT entry write port (any state)
//   cfg_en/cfg_lut/cfg_wrap        per-LUT edge mode write (1 = wrap)
module lut_engine_rr #(
  parameter int DATA_WIDTH   = 16,
  parameter int N_CH         = 2,
  parameter int N_LUTS       = 4,
  parameter int ADDR_WIDTH   = 6,
  parameter int FRAC_WIDTH   = 4,
  parameter int HANDLE_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_CH-1:0]                req,
  input  logic [N_CH*HANDLE_WIDTH-1:0]   req_handle,
  input  logic [N_CH*DATA_WIDTH-1:0]     req_arg,
  output logic [N_CH-1:0]                req_ack,
  output logic [N_CH-1:0]                resp_valid,
  output logic signed [DATA_WIDTH-1:0]   resp_data,
  output logic                           resp_err,
  output logic                           busy,
  input  logic                           wr_en,
  input  logic [HANDLE_WIDTH-1:0]        wr_lut,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic signed [DATA_WIDTH-1:0]   wr_data,
  input  logic                           cfg_en,
  input  logic [HANDLE_WIDTH-1:0]        cfg_lut,
  input  logic                           cfg_wrap
);

  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int PTR_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int LUT_W   = (N_LUTS > 1) ? $clog2(N_LUTS) : 1;
  localparam int K_W     = (FRAC_WIDTH > 1) ? $clog2(FRAC_WIDTH) : 1;
  localparam int DIFF_W  = DATA_WIDTH + 1;
  localparam int PROD_W  = DATA_WIDTH + FRAC_WIDTH + 1;
  localparam int KEY_W   = ADDR_WIDTH + FRAC_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_MAC   = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  function automatic logic handle_ok(input logic [HANDLE_WIDTH-1:0] h);
    return 32'(h) < 32'(N_LUTS);
  endfunction

  // Floor division by 2^FRAC_WIDTH is an arithmetic shift; the sum always
  // lies between base and next, so truncation to DATA_WIDTH is exact.
  function automatic logic signed [DATA_WIDTH-1:0] interp_sum(
    input logic signed [DATA_WIDTH-1:0] base,
    input logic signed [PROD_W-1:0]     prod
  );
    return DATA_WIDTH'((prod >>> FRAC_WIDTH) + PROD_W'(base));
  endfunction

  logic [1:0]                    state;
  logic [PTR_W-1:0]              ptr;
  logic [N_LUTS-1:0]             wrap_mode;
  logic signed [DATA_WIDTH-1:0]  lut_mem [N_LUTS][DEPTH];

  // arbitration
  logic                          gnt_any;
  logic [PTR_W-1:0]              gnt_ch;
  logic [HANDLE_WIDTH-1:0]       gnt_handle;

  always_comb begin
    gnt_any = 1'b0;
    gnt_ch  = '0;
    for (int i = 0; i < N_CH; i++) begin
      logic [PTR_W-1:0] c;
      c = PTR_W'((int'(ptr) + i) % N_CH);
      if (!gnt_any && req[c]) begin
        gnt_any = 1'b1;
        gnt_ch  = c;
      end
    end
    gnt_handle = req_handle[gnt_ch*HANDLE_WIDTH +: HANDLE_WIDTH];
  end

  // ---- stage p0: request captured at grant ----
  logic [N_CH-1:0]               gnt_p0;
  logic [LUT_W-1:0]              lut_p0;
  logic [KEY_W-1:0]              key_p0;

  logic [ADDR_WIDTH-1:0]         idx;
  logic [ADDR_WIDTH-1:0]         next_addr;
  logic signed [DATA_WIDTH-1:0]  base_rd;
  logic signed [DATA_WIDTH-1:0]  next_rd;

  always_comb begin
    idx = key_p0[KEY_W-1 -: ADDR_WIDTH];
    // top entry wraps to entry 0 or repeats itself depending on edge mode
    if (&idx && !wrap_mode[lut_p0])
      next_addr = idx;
    else
      next_addr = idx + 1'b1;
    base_rd = lut_mem[lut_p0][idx];
    next_rd = lut_mem[lut_p0][next_addr];
  end

  // ---- stage p1: operands fetched, shift-add in progress ----
  logic signed [DATA_WIDTH-1:0]  base_p1;
  logic signed [DIFF_W-1:0]      diff_p1;
  logic [FRAC_WIDTH-1:0]         frac_p1;
  logic [K_W-1:0]                bit_p1;
  logic signed [PROD_W-1:0]      acc_p1;

  logic signed [PROD_W-1:0]      addend;
  logic signed [PROD_W-1:0]      acc_nxt;

  always_comb begin
    addend  = frac_p1[bit_p1] ? (PROD_W'(diff_p1) <<< bit_p1) : '0;
    acc_nxt = acc_p1 + addend;
  end

  // LUT storage: never reset; reads above see the pre-write contents
  always_ff @(posedge clk) begin
    if (wr_en && handle_ok(wr_lut))
      lut_mem[wr_lut[LUT_W-1:0]][wr_addr] <= wr_data;
  end

  // datapath registers carry no reset; the FSM qualifies them
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (gnt_any) begin
          gnt_p0         <= '0;
          gnt_p0[gnt_ch] <= 1'b1;
          lut_p0         <= gnt_handle[LUT_W-1:0];
          key_p0         <= req_arg[gnt_ch*DATA_WIDTH + DATA_WIDTH-1 -: KEY_W];
        end
      end
      S_FETCH: begin
        base_p1 <= base_rd;
        diff_p1 <= DIFF_W'(next_rd) - DIFF_W'(base_rd);
        frac_p1 <= key_p0[FRAC_WIDTH-1:0];
        bit_p1  <= K_W'(FRAC_WIDTH - 1);
        acc_p1  <= '0;
      end
      S_MAC: begin
        acc_p1 <= acc_nxt;
        bit_p1 <= bit_p1 - 1'b1;
      end
      default: ;
    endcase
  end

  // ---- stage p2: control, mode registers and response ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      wrap_mode  <= '0;
      req_ack    <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      req_ack    <= '0;
      resp_valid <= '0;
      resp_err   <= 1'b0;
      if (cfg_en && handle_ok(cfg_lut))
        wrap_mode[cfg_lut[LUT_W-1:0]] <= cfg_wrap;
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            req_ack[gnt_ch] <= 1'b1;
            ptr             <= PTR_W'((int'(gnt_ch) + 1) % N_CH);
            state           <= handle_ok(gnt_handle) ? S_FETCH : S_ERR;
          end
        end
        S_FETCH: state <= S_MAC;
        S_MAC: begin
          if (bit_p1 == '0) begin
            resp_data  <= interp_sum(base_p1, acc_nxt);
            resp_valid <= gnt_p0;
            state      <= S_IDLE;
          end
        end
        default: begin
          resp_data  <= '0;
          resp_err   <= 1'b1;
          resp_valid <= gnt_p0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_lut_engine_rr.sv
// Directed testbench for lut_engine_rr (default parameters).
// Arguments are built as idx<<10 | frac<<6.
module tb_lut_engine_rr;

  logic               clk;
  logic               reset;
  logic [1:0]         req;
  logic [5:0]         req_handle;
  logic [31:0]        req_arg;
  logic [1:0]         req_ack;
  logic [1:0]         resp_valid;
  logic signed [15:0] resp_data;
  logic               resp_err;
  logic               busy;
  logic               wr_en;
  logic [2:0]         wr_lut;
  logic [5:0]         wr_addr;
  logic signed [15:0] wr_data;
  logic               cfg_en;
  logic [2:0]         cfg_lut;
  logic               cfg_wrap;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  lut_engine_rr dut (
    .clk(clk), .reset(reset),
    .req(req), .req_handle(req_handle), .req_arg(req_arg),
    .req_ack(req_ack), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy),
    .wr_en(wr_en), .wr_lut(wr_lut), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_en(cfg_en), .cfg_lut(cfg_lut), .cfg_wrap(cfg_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wr_entry(input logic [2:0] l, input logic [5:0] a,
                          input logic signed [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_lut = l; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic set_mode(input logic [2:0] l, input logic w);
    @(negedge clk);
    cfg_en = 1'b1; cfg_lut = l; cfg_wrap = w;
    @(negedge clk);
    cfg_en = 1'b0;
  endtask

  // Single-channel transaction. With coll set, a write LUT0[5]=300 is driven
  // in the FETCH cycle.
  task automatic do_req(input string tag, input int ch, input logic [2:0] h,
                        input logic [15:0] arg, input int exp_data,
                        input int exp_err, input int exp_lat, input bit coll);
    int n;
    int e0;
    @(negedge clk);
    req[ch] = 1'b1;
    req_handle[ch*3 +: 3] = h;
    req_arg[ch*16 +: 16]  = arg;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ack == 2'b00 && n < 40);
    chk({tag, "_ack"}, req_ack, 1 << ch);
    req[ch] = 1'b0;
    if (req_ack == 2'b00) return;
    e0 = cyc;
    chk({tag, "_busy"}, busy, 1);
    if (coll) begin
      wr_en = 1'b1; wr_lut = 3'd0; wr_addr = 6'd5; wr_data = 16'sd300;
    end
    n = 0;
    do begin
      @(negedge clk);
      wr_en = 1'b0;
      n++;
    end while (resp_valid == 2'b00 && n < 40);
    chk({tag, "_rv"},   resp_valid, 1 << ch);
    chk({tag, "_data"}, resp_data, exp_data);
    chk({tag, "_err"},  resp_err, exp_err);
    chk({tag, "_lat"},  cyc - e0, exp_lat);
    @(negedge clk);
    chk({tag, "_rvoff"}, {resp_valid, resp_err}, 0);
  endtask

  initial begin
    int n;
    int cnt;
    int g_n;
    int r_n;
    int last_g;

    reset = 1'b0; req = '0; req_handle = '0; req_arg = '0;
    wr_en = 1'b0; wr_lut = '0; wr_addr = '0; wr_data = '0;
    cfg_en = 1'b0; cfg_lut = '0; cfg_wrap = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack",  req_ack, 0);
    chk("rst_rv",   resp_valid, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_err",  resp_err, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;

    wr_entry(3'd0, 6'd5, 16'sd100);
    wr_entry(3'd0, 6'd6, 16'sd200);
    wr_entry(3'd1, 6'd5, 16'sd200);
    wr_entry(3'd1, 6'd6, -16'sd101);
    wr_entry(3'd2, 6'd63, 16'sd1000);
    wr_entry(3'd2, 6'd0, 16'sd0);

    do_req("basic", 0, 3'd0, 16'h1600, 150, 0, 5, 1'b0);
    do_req("neg",   0, 3'd1, 16'h1600, 49,  0, 5, 1'b0);

    // out-of-range write handle would alias onto LUT0 if not rejected
    wr_entry(3'd4, 6'd5, 16'sd999);
    do_req("badwr", 1, 3'd0, 16'h1600, 150, 0, 5, 1'b0);

    do_req("inval", 1, 3'd5, 16'h1600, 0,   1, 1, 1'b0);
    do_req("after", 1, 3'd0, 16'h1600, 150, 0, 5, 1'b0);

    do_req("clamp", 0, 3'd2, 16'hFD00, 1000, 0, 5, 1'b0);
    set_mode(3'd6, 1'b1);
    do_req("badcfg", 0, 3'd2, 16'hFD00, 1000, 0, 5, 1'b0);
    set_mode(3'd2, 1'b1);
    do_req("wrap",  0, 3'd2, 16'hFD00, 750,  0, 5, 1'b0);
    do_req("wrapf0", 0, 3'd2, 16'hFC00, 1000, 0, 5, 1'b0);

    // reset pulse in the middle of the shift-add loop
    @(negedge clk);
    req[0] = 1'b1; req_handle[2:0] = 3'd0; req_arg[15:0] = 16'h1600;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ack == 2'b00 && n < 40);
    chk("mid_ack", req_ack, 1);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mid_busy", busy, 0);
    chk("mid_rv", resp_valid, 0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid != 2'b00) cnt++;
    end
    chk("mid_norsp", cnt, 0);
    do_req("mid_clamp", 0, 3'd2, 16'hFD00, 1000, 0, 5, 1'b0);
    do_req("mid_keep0", 0, 3'd0, 16'h1600, 150,  0, 5, 1'b0);
    do_req("mid_keep1", 1, 3'd1, 16'h1600, 49,   0, 5, 1'b0);

    // both channels request continuously from reset
    @(negedge clk);
    reset = 1'b0;
    req = 2'b11;
    req_handle = {3'd1, 3'd0};
    req_arg = {16'h1600, 16'h1600};
    @(negedge clk);
    reset = 1'b1;
    g_n = 0; r_n = 0; last_g = 0; n = 0;
    while (r_n < 4 && n < 80) begin
      @(negedge clk);
      n++;
      if (req_ack != 2'b00) begin
        chk("arb_ack", req_ack, (g_n % 2 == 0) ? 1 : 2);
        if (g_n > 0) chk("arb_gap", cyc - last_g, 6);
        last_g = cyc;
        g_n++;
        if (g_n == 4) req = 2'b00;
      end
      if (resp_valid != 2'b00) begin
        chk("arb_rv",   resp_valid, (r_n % 2 == 0) ? 1 : 2);
        chk("arb_data", resp_data,  (r_n % 2 == 0) ? 150 : 49);
        r_n++;
      end
    end
    chk("arb_count", r_n, 4);
    req = 2'b00;
    repeat (3) @(negedge clk);

    do_req("coll",  0, 3'd0, 16'h1600, 150, 0, 5, 1'b1);
    do_req("coll2", 0, 3'd0, 16'h1600, 250, 0, 5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lut_engine_rr.md
Name: lut_engine_rr

Overview:
- Multi-channel, parametrised LUT evaluation engine for the effect datapath. It succeeds the single-requester LUT master.
- Holds N_LUTS writable LUTs in a register array. Each LUT has a per-LUT wrap/clamp edge mode.
- Arbitrates N_CH requesters round-robin.
- Returns an exactly defined linear interpolation, computed sequentially with shift-add over FRAC_WIDTH cycles.

Parameters:
DATA_WIDTH, 16, sample and argument width (signed samples, unsigned argument)
N_CH, 2, number of requesting channels (>=1)
N_LUTS, 4, number of LUTs
ADDR_WIDTH, 6, log2 of LUT depth (depth = 2^ADDR_WIDTH)
FRAC_WIDTH, 4, interpolation fraction bits; ADDR_WIDTH+FRAC_WIDTH <= DATA_WIDTH
HANDLE_WIDTH, 3, LUT handle width; must be >= clog2(N_LUTS)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (reset==0 resets on the rising clk edge)
req  in  N_CH  per-channel request; held high until the matching req_ack
req_handle  in  N_CH*HANDLE_WIDTH  per-channel LUT handle; channel c occupies bits [c*HW +: HW]
req_arg  in  N_CH*DATA_WIDTH  per-channel argument; channel c occupies bits [c*DW +: DW]
req_ack  out  N_CH  one-hot, one-cycle grant pulse
resp_valid  out  N_CH  one-hot, one-cycle response pulse to the granted channel
resp_data  out  DATA_WIDTH  signed result; valid while resp_valid is non-zero
resp_err  out  1  high with resp_valid when the handle was invalid
busy  out  1  high whenever the state is not IDLE
wr_en  in  1  LUT entry write strobe
wr_lut  in  HANDLE_WIDTH  target LUT for the write
wr_addr  in  ADDR_WIDTH  target entry
wr_data  in  DATA_WIDTH  entry value
cfg_en  in  1  mode write strobe
cfg_lut  in  HANDLE_WIDTH  target LUT for the mode write
cfg_wrap  in  1  1 = wrap mode (periodic), 0 = clamp mode

Behaviour:
- Reset outputs: req_ack=0, resp_valid=0, resp_data=0, resp_err=0, busy=0.
- Reset internal state: state=IDLE, round-robin pointer=0, all LUT modes=clamp. LUT entries are not cleared.
- Reset mid-operation: the operation is aborted and no response is issued. A req still held after reset is re-arbitrated.
- Argument decode:
  - idx = arg[DW-1 -: ADDR_WIDTH]
  - frac = arg[DW-1-ADDR_WIDTH -: FRAC_WIDTH]
  - remaining low bits are ignored
- Next sample:
  - idx < depth-1: entry[idx+1].
  - idx = depth-1, wrap mode: entry[0].
  - idx = depth-1, clamp mode: entry[idx].
- Result arithmetic:
  - result = base + floor((next-base)*frac / 2^FRAC_WIDTH).
  - diff is computed at DATA_WIDTH+1 bits and the product at DATA_WIDTH+FRAC_WIDTH+1 bits, both signed.
  - Floor is an arithmetic right shift. The final sum is truncated to DATA_WIDTH. No saturation is needed, because the result lies between base and next.
- States:
  - IDLE: if any req bit is high, grant the first requesting channel at or after the pointer (cyclic order). That edge pulses req_ack for the granted channel, latches handle and arg, sets pointer = (granted+1) mod N_CH, and sets busy.
    - Handle >= N_LUTS: go to ERR.
    - Otherwise: go to FETCH.
  - FETCH: read base and next from the array in one cycle, latch them, load frac, go to MAC.
  - MAC: one frac bit per cycle (MSB first), accumulating diff<<k for each set bit k. Exactly FRAC_WIDTH cycles. The last MAC edge registers resp_data, resp_err=0 and resp_valid (granted one-hot), and returns to IDLE.
  - ERR: one edge registers resp_valid (granted one-hot), resp_err=1 and resp_data=0, and returns to IDLE.
- Latency, with E0 as the grant edge:
  - Valid handle: response visible after edge E0+FRAC_WIDTH+1. Next grant is possible at E0+FRAC_WIDTH+2.
  - Invalid handle: response visible after E0+1.
  - resp_valid, resp_err and req_ack are high for exactly one cycle. resp_data holds its value until the next response.
- Handshake:
  - req is sampled only in IDLE.
  - A requester keeps req, handle and arg stable until it sees req_ack.
  - If req is still high in the cycle after req_ack, that is a new request.
  - Non-granted channels wait without loss.
- Writes and mode writes:
  - Both are accepted in any state on the same edge.
  - Writes with wr_lut >= N_LUTS, and mode writes with cfg_lut >= N_LUTS, are ignored.
  - A write in the same cycle as FETCH returns the pre-write value to the fetch (read-before-write). The new value applies to later requests.
  - A mode change takes effect at the next FETCH.
- Simultaneous requests with the pointer at p: the channel closest to p in cyclic order wins. N_CH=1 degenerates to a single-requester engine.

Test Plan:
(Defaults throughout. arg = idx<<10 | frac<<6.)
- Basic interpolation: LUT0[5]=100, LUT0[6]=200; ch0 requests handle 0, arg 0x1600 (idx 5, frac 8) -> req_ack[0] pulse, then resp_valid=01 exactly 5 cycles after the grant edge, resp_data=150, resp_err=0.
- Negative diff / floor: LUT1[5]=200, LUT1[6]=-101; handle 1, arg 0x1600 -> resp_data=49 (floor of -150.5 is -151).
- Edge modes: LUT2[63]=1000, LUT2[0]=0, arg 0xFD00 (idx 63, frac 4):
  - clamp (after reset) -> 1000.
  - after cfg_en with cfg_lut=2, cfg_wrap=1 -> 750.
  - frac 0 -> 1000 in both modes.
- Invalid handle: ch1 requests handle 5 -> req_ack=10, resp_valid=10 one cycle later, resp_err=1, resp_data=0. The array is untouched, and a following valid request is served normally.
- Arbitration: ch0 and ch1 both hold req continuously from reset -> grants alternate 0,1,0,1. Each response goes to the matching one-hot bit. No request is dropped, and grants are FRAC_WIDTH+2 cycles apart.
- Reset / collision:
  - reset=0 for one cycle during MAC -> no resp_valid, busy=0 next cycle, modes return to clamp, LUT entries are retained.
  - wr_en to LUT0[5]=300 during FETCH of the basic request -> 150 is returned, and the next identical request returns 250.
